dataram_copier: RTL

- Memory-side initiator for the `dataram` single-port interface (`memwrite`/`adr`/`writedata`/`readdata`).
- Copies a block of N words from a source word address to a destination word address, one word at a time, using the same port.
- Sits between a control source (test bench, boot loader or CPU-side register) and `dataram`.
- Signals completion with a one-cycle `done` pulse.

---
 rtl/dataram_copier.sv | 102 ++++++++++
 1 files changed

// File: rtl/dataram_copier.sv
// Block-copy initiator for the single-port dataram: moves len words from src
// to dst, one read cycle and one write cycle per word, then pulses done.
module dataram_copier #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 17,
    parameter int LEN_WIDTH  = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BUS_WIDTH-1:0]  src,
    input  logic [BUS_WIDTH-1:0]  dst,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  memwrite,
    output logic [BUS_WIDTH-1:0]  adr,
    output logic [DATA_WIDTH-1:0] writedata,
    input  logic [DATA_WIDTH-1:0] readdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [BUS_WIDTH-1:0]  r_src_ptr;
    logic [BUS_WIDTH-1:0]  r_dst_ptr;
    logic [LEN_WIDTH-1:0]  r_count;
    logic [DATA_WIDTH-1:0] r_buffer;
    logic                  w_last_word;

    assign w_last_word = (r_count == LEN_WIDTH'(1));

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_count   <= '0;
            r_buffer  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_src_ptr <= src;
                            r_dst_ptr <= dst;
                            r_count   <= len;
                            r_state   <= S_READ;
                        end else begin
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    r_buffer <= readdata;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    // Pointers wrap modulo 2^BUS_WIDTH by natural truncation.
                    r_src_ptr <= r_src_ptr + 1'b1;
                    r_dst_ptr <= r_dst_ptr + 1'b1;
                    r_count   <= r_count - 1'b1;
                    r_state   <= w_last_word ? S_DONE : S_READ;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // NOTE: every output gets a default first, so no latch can be inferred.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        memwrite  = 1'b0;
        adr       = '0;
        writedata = r_buffer;
        case (r_state)
            S_READ: begin
                busy = 1'b1;
                adr  = r_src_ptr;
            end
            S_WRITE: begin
                busy     = 1'b1;
                memwrite = 1'b1;
                adr      = r_dst_ptr;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
